mips_multicycle_ctrl: RTL and testbench

Multicycle MIPS control unit: the producer side of the ALU interface. It sequences fetch / decode / execute / memory / writeback for each instruction. Each cycle it drives the ALU operation code and datapath selects, and consumes the ALU `Zero` flag for branches. It sits between the instruction register and the shared datapath (register file, ALU, unified memory).

---
 rtl/mips_pkg.sv | 65 ++++++
 rtl/alu_decoder.sv | 48 ++++
 rtl/mips_multicycle_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and types for the multicycle MIPS control unit
//
// Purpose: ALU control codes, opcode/funct constants, ALU decoder modes,
//          ALUSrcB/PCSource encodings and the controller state enum.
// Ports:   none (package).
package mips_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [1:0] {
    ALU_M_ADD,
    ALU_M_SUB,
    ALU_M_FUNCT,
    ALU_M_IMM
  } alu_mode_t;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_RTYPE_EX,
    S_RTYPE_WB,
    S_IMM_EX,
    S_IMM_WB,
    S_BEQ,
    S_JUMP
  } state_t;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps controller mode plus opcode/funct to an ALU control code
//
// Purpose: combinational ALU control decode.
// Ports:   mode     in  2  ADD / SUB / FUNCT (R-type) / IMM (I-type by opcode)
//          opcode   in  6  latched instruction opcode (used in IMM mode)
//          funct    in  6  instruction funct field (used in FUNCT mode)
//          alu_ctrl out 4  ALU operation code
//          illegal  out 1  unsupported funct in FUNCT mode
module alu_decoder
  import mips_pkg::*;
(
  input  alu_mode_t   mode,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  output logic [3:0]  alu_ctrl,
  output logic        illegal
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    illegal  = 1'b0;
    case (mode)
      ALU_M_ADD: alu_ctrl = ALU_ADD;
      ALU_M_SUB: alu_ctrl = ALU_SUB;
      ALU_M_FUNCT: begin
        case (funct)
          FN_ADD, FN_ADDU: alu_ctrl = ALU_ADD;
          FN_SUB, FN_SUBU: alu_ctrl = ALU_SUB;
          FN_AND:          alu_ctrl = ALU_AND;
          FN_OR:           alu_ctrl = ALU_OR;
          FN_NOR:          alu_ctrl = ALU_NOR;
          FN_SLT:          alu_ctrl = ALU_SLT;
          default:         illegal  = 1'b1;
        endcase
      end
      ALU_M_IMM: begin
        // DECODE already filtered opcodes, so anything else here is addi.
        case (opcode)
          OP_ANDI: alu_ctrl = ALU_AND;
          OP_ORI:  alu_ctrl = ALU_OR;
          OP_SLTI: alu_ctrl = ALU_SLT;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM driving the shared datapath
//
// Purpose: sequences fetch/decode/execute/memory/writeback per instruction.
// Ports:   clk, rst (sync, active high); Opcode/Funct from IR; Zero from ALU
//          (the datapath forms PCWrite | (PCWriteCond & Zero)); Mem_Ready from memory;
//          ALUctrl, ALUSrcA, ALUSrcB, PCSource selects; datapath strobes;
//          Illegal pulse; Instr_Count retired-instruction counter.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       Opcode,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             Mem_Ready,
  output logic [3:0]       ALUctrl,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSource,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             Illegal,
  output logic [CNT_W-1:0] Instr_Count
);

  state_t     state, next_state;
  logic [5:0] op_q;
  alu_mode_t  mode;
  logic       dec_illegal;
  logic       op_illegal;
  logic       retire;

  // Zero is consumed by the datapath's branch PC-write gate, not by the FSM.
  logic unused_zero;
  assign unused_zero = Zero;

  alu_decoder u_alu_decoder (
    .mode     (mode),
    .opcode   (op_q),
    .funct    (Funct),
    .alu_ctrl (ALUctrl),
    .illegal  (dec_illegal)
  );

  assign Illegal = op_illegal | dec_illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH;
      op_q        <= 6'b0;
      Instr_Count <= '0;
    end else begin
      state <= next_state;
      // Hold the opcode so MEMADR/IMM_EX do not depend on the IR staying put.
      if (state == S_DECODE) op_q <= Opcode;
      if (retire) Instr_Count <= Instr_Count + CNT_W'(1);
    end
  end

  // Decoder mode is kept in its own block so the main block can read the
  // decoder's illegal flag without forming a combinational loop.
  always_comb begin
    mode = ALU_M_ADD;
    if (!rst) begin
      case (state)
        S_RTYPE_EX: mode = ALU_M_FUNCT;
        S_IMM_EX:   mode = ALU_M_IMM;
        S_BEQ:      mode = ALU_M_SUB;
        default:    mode = ALU_M_ADD;
      endcase
    end
  end

  always_comb begin
    next_state  = state;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    PCSource    = PCSRC_ALU;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    op_illegal  = 1'b0;
    retire      = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_FOUR;
          if (Mem_Ready) begin
            IRWrite    = 1'b1;
            PCWrite    = 1'b1;
            next_state = S_DECODE;
          end
        end
        S_DECODE: begin
          ALUSrcB = SRCB_IMMSH2;
          case (Opcode)
            OP_RTYPE:                         next_state = S_RTYPE_EX;
            OP_LW, OP_SW:                     next_state = S_MEMADR;
            OP_BEQ:                           next_state = S_BEQ;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: next_state = S_IMM_EX;
            OP_J:                             next_state = S_JUMP;
            default: begin
              next_state = S_FETCH;
              op_illegal = 1'b1;
            end
          endcase
        end
        S_MEMADR: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = SRCB_IMM;
          next_state = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          if (Mem_Ready) next_state = S_MEMWB;
        end
        S_MEMWB: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          retire     = 1'b1;
          next_state = S_FETCH;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
          if (Mem_Ready) begin
            retire     = 1'b1;
            next_state = S_FETCH;
          end
        end
        S_RTYPE_EX: begin
          ALUSrcA    = 1'b1;
          next_state = dec_illegal ? S_FETCH : S_RTYPE_WB;
        end
        S_RTYPE_WB: begin
          RegWrite   = 1'b1;
          RegDst     = 1'b1;
          retire     = 1'b1;
          next_state = S_FETCH;
        end
        S_IMM_EX: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = SRCB_IMM;
          next_state = S_IMM_WB;
        end
        S_IMM_WB: begin
          RegWrite   = 1'b1;
          retire     = 1'b1;
          next_state = S_FETCH;
        end
        S_BEQ: begin
          ALUSrcA     = 1'b1;
          PCWriteCond = 1'b1;
          PCSource    = PCSRC_ALUOUT;
          retire      = 1'b1;
          next_state  = S_FETCH;
        end
        S_JUMP: begin
          PCWrite    = 1'b1;
          PCSource   = PCSRC_JUMP;
          retire     = 1'b1;
          next_state = S_FETCH;
        end
        default: next_state = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - directed vector bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  Opcode, Funct;
  logic        Zero, Mem_Ready;
  logic [3:0]  ALUctrl;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB, PCSource;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegDst, RegWrite, Illegal;
  logic [31:0] Instr_Count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .Mem_Ready(Mem_Ready), .ALUctrl(ALUctrl), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .Illegal(Illegal),
    .Instr_Count(Instr_Count)
  );

  // Output word: {ALUctrl, ALUSrcA, ALUSrcB, PCSource,
  //   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, Illegal}
  logic [18:0] obs;
  assign obs = {ALUctrl, ALUSrcA, ALUSrcB, PCSource, PCWrite, PCWriteCond, IorD,
                MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, Illegal};

  localparam logic [18:0] E_RST        = {4'b0010, 1'b0, 2'b00, 2'b00, 10'b0000000000};
  localparam logic [18:0] E_FETCH_WAIT = {4'b0010, 1'b0, 2'b01, 2'b00, 10'b0001000000};
  localparam logic [18:0] E_FETCH_RDY  = {4'b0010, 1'b0, 2'b01, 2'b00, 10'b1001010000};
  localparam logic [18:0] E_DECODE     = {4'b0010, 1'b0, 2'b11, 2'b00, 10'b0000000000};
  localparam logic [18:0] E_DECODE_ILL = {4'b0010, 1'b0, 2'b11, 2'b00, 10'b0000000001};
  localparam logic [18:0] E_REX_ILL    = {4'b0010, 1'b1, 2'b00, 2'b00, 10'b0000000001};
  localparam logic [18:0] E_RWB        = {4'b0010, 1'b0, 2'b00, 2'b00, 10'b0000000110};
  localparam logic [18:0] E_MEMADR     = {4'b0010, 1'b1, 2'b10, 2'b00, 10'b0000000000};
  localparam logic [18:0] E_MEMRD      = {4'b0010, 1'b0, 2'b00, 2'b00, 10'b0011000000};
  localparam logic [18:0] E_MEMWB      = {4'b0010, 1'b0, 2'b00, 2'b00, 10'b0000001010};
  localparam logic [18:0] E_MEMWR      = {4'b0010, 1'b0, 2'b00, 2'b00, 10'b0010100000};
  localparam logic [18:0] E_IMM_WB     = {4'b0010, 1'b0, 2'b00, 2'b00, 10'b0000000010};
  localparam logic [18:0] E_BEQ        = {4'b0110, 1'b1, 2'b00, 2'b01, 10'b0100000000};
  localparam logic [18:0] E_JUMP       = {4'b0010, 1'b0, 2'b00, 2'b10, 10'b1000000000};

  function automatic logic [18:0] e_rex(input logic [3:0] a);
    return {a, 1'b1, 2'b00, 2'b00, 10'b0000000000};
  endfunction
  function automatic logic [18:0] e_imm(input logic [3:0] a);
    return {a, 1'b1, 2'b10, 2'b00, 10'b0000000000};
  endfunction

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        zero;
    logic        mr;
    logic [18:0] exp;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic mr, input logic [18:0] e,
                     input logic [31:0] c);
    vec_t v;
    v.rst = r; v.op = op; v.fn = fn; v.zero = z; v.mr = mr; v.exp = e; v.cnt = c;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic mr);
    @(negedge clk);
    rst = r; Opcode = op; Funct = fn; Zero = z; Mem_Ready = mr;
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; Opcode = 6'b0; Funct = 6'b0; Zero = 1'b0; Mem_Ready = 1'b0;
    @(posedge clk);

    // reset, then add (R-type)
    add(1, 6'b000000, 6'b100000, 0, 1, E_RST,        0);
    add(0, 6'b000000, 6'b100000, 0, 1, E_FETCH_RDY,  0);
    add(0, 6'b000000, 6'b100000, 0, 1, E_DECODE,     0);
    add(0, 6'b000000, 6'b100000, 0, 1, e_rex(4'b0010), 0);
    add(0, 6'b000000, 6'b100000, 0, 1, E_RWB,        0);
    // lw with two stall cycles in MEMRD
    add(0, 6'b100011, 6'b000000, 0, 1, E_FETCH_RDY,  1);
    add(0, 6'b100011, 6'b000000, 0, 1, E_DECODE,     1);
    add(0, 6'b100011, 6'b000000, 0, 1, E_MEMADR,     1);
    add(0, 6'b100011, 6'b000000, 0, 0, E_MEMRD,      1);
    add(0, 6'b100011, 6'b000000, 0, 0, E_MEMRD,      1);
    add(0, 6'b100011, 6'b000000, 0, 1, E_MEMRD,      1);
    add(0, 6'b100011, 6'b000000, 0, 1, E_MEMWB,      1);
    // beq taken, then not taken
    add(0, 6'b000100, 6'b000000, 1, 1, E_FETCH_RDY,  2);
    add(0, 6'b000100, 6'b000000, 1, 1, E_DECODE,     2);
    add(0, 6'b000100, 6'b000000, 1, 1, E_BEQ,        2);
    add(0, 6'b000100, 6'b000000, 0, 1, E_FETCH_RDY,  3);
    add(0, 6'b000100, 6'b000000, 0, 1, E_DECODE,     3);
    add(0, 6'b000100, 6'b000000, 0, 1, E_BEQ,        3);
    // ori
    add(0, 6'b001101, 6'b000000, 0, 1, E_FETCH_RDY,  4);
    add(0, 6'b001101, 6'b000000, 0, 1, E_DECODE,     4);
    add(0, 6'b001101, 6'b000000, 0, 1, e_imm(4'b0001), 4);
    add(0, 6'b001101, 6'b000000, 0, 1, E_IMM_WB,     4);
    // slti
    add(0, 6'b001010, 6'b000000, 0, 1, E_FETCH_RDY,  5);
    add(0, 6'b001010, 6'b000000, 0, 1, E_DECODE,     5);
    add(0, 6'b001010, 6'b000000, 0, 1, e_imm(4'b0111), 5);
    add(0, 6'b001010, 6'b000000, 0, 1, E_IMM_WB,     5);
    // nor
    add(0, 6'b000000, 6'b100111, 0, 1, E_FETCH_RDY,  6);
    add(0, 6'b000000, 6'b100111, 0, 1, E_DECODE,     6);
    add(0, 6'b000000, 6'b100111, 0, 1, e_rex(4'b1100), 6);
    add(0, 6'b000000, 6'b100111, 0, 1, E_RWB,        6);
    // illegal opcode
    add(0, 6'b111111, 6'b000000, 0, 1, E_FETCH_RDY,  7);
    add(0, 6'b111111, 6'b000000, 0, 1, E_DECODE_ILL, 7);
    // illegal funct
    add(0, 6'b000000, 6'b000000, 0, 1, E_FETCH_RDY,  7);
    add(0, 6'b000000, 6'b000000, 0, 1, E_DECODE,     7);
    add(0, 6'b000000, 6'b000000, 0, 1, E_REX_ILL,    7);
    // j with a fetch stall
    add(0, 6'b000010, 6'b000000, 0, 0, E_FETCH_WAIT, 7);
    add(0, 6'b000010, 6'b000000, 0, 1, E_FETCH_RDY,  7);
    add(0, 6'b000010, 6'b000000, 0, 1, E_DECODE,     7);
    add(0, 6'b000010, 6'b000000, 0, 1, E_JUMP,       7);
    // sw with one stall
    add(0, 6'b101011, 6'b000000, 0, 1, E_FETCH_RDY,  8);
    add(0, 6'b101011, 6'b000000, 0, 1, E_DECODE,     8);
    add(0, 6'b101011, 6'b000000, 0, 1, E_MEMADR,     8);
    add(0, 6'b101011, 6'b000000, 0, 0, E_MEMWR,      8);
    add(0, 6'b101011, 6'b000000, 0, 1, E_MEMWR,      8);
    // sw abandoned by reset while stalled
    add(0, 6'b101011, 6'b000000, 0, 1, E_FETCH_RDY,  9);
    add(0, 6'b101011, 6'b000000, 0, 1, E_DECODE,     9);
    add(0, 6'b101011, 6'b000000, 0, 1, E_MEMADR,     9);
    add(0, 6'b101011, 6'b000000, 0, 0, E_MEMWR,      9);
    add(1, 6'b101011, 6'b000000, 0, 0, E_RST,        9);
    add(0, 6'b001100, 6'b000000, 0, 0, E_FETCH_WAIT, 0);
    // andi, then sub
    add(0, 6'b001100, 6'b000000, 0, 1, E_FETCH_RDY,  0);
    add(0, 6'b001100, 6'b000000, 0, 1, E_DECODE,     0);
    add(0, 6'b001100, 6'b000000, 0, 1, e_imm(4'b0000), 0);
    add(0, 6'b001100, 6'b000000, 0, 1, E_IMM_WB,     0);
    add(0, 6'b000000, 6'b100010, 0, 1, E_FETCH_RDY,  1);
    add(0, 6'b000000, 6'b100010, 0, 1, E_DECODE,     1);
    add(0, 6'b000000, 6'b100010, 0, 1, e_rex(4'b0110), 1);
    add(0, 6'b000000, 6'b100010, 0, 1, E_RWB,        1);
    add(0, 6'b000000, 6'b100010, 0, 0, E_FETCH_WAIT, 2);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].op, tbl[i].fn, tbl[i].zero, tbl[i].mr);
      chk($sformatf("vec%0d outputs", i), {13'b0, obs}, {13'b0, tbl[i].exp});
      chk($sformatf("vec%0d count", i), Instr_Count, tbl[i].cnt);
    end

    // Illegal pulse width and counter across an illegal opcode followed by j.
    begin
      int ill_cycles;
      ill_cycles = 0;
      drive(1, 6'b111111, 6'b0, 0, 1);
      drive(0, 6'b111111, 6'b0, 0, 1);
      ill_cycles += int'(Illegal);
      drive(0, 6'b111111, 6'b0, 0, 1);
      ill_cycles += int'(Illegal);
      for (int c = 0; c < 3; c++) begin
        drive(0, 6'b000010, 6'b0, 0, 1);
        ill_cycles += int'(Illegal);
      end
      chk("illegal_pulse_cycles", ill_cycles, 1);
      drive(0, 6'b000010, 6'b0, 0, 1);
      chk("count_after_illegal_then_j", Instr_Count, 1);
    end

    // lw latency with Mem_Ready held high: MemtoReg appears in cycle 4 (fetch = 0).
    begin
      int cyc;
      bit seen;
      seen = 1'b0;
      cyc = -1;
      drive(1, 6'b100011, 6'b0, 0, 1);
      for (int c = 0; c < 12 && !seen; c++) begin
        drive(0, 6'b100011, 6'b0, 0, 1);
        if (MemtoReg) begin
          seen = 1'b1;
          cyc = c;
        end
      end
      chk("lw_latency_index", cyc, 4);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
